hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage in-order pipeline. It detects
// three hazards:
//   * load-use : the instruction in EX is a load whose destination is read
//                by the instruction in ID
//   * branch   : an ID-stage branch/jump reads busA, whose producer is still
//                in EX (any writer) or is a load in MEM
//   * mem wait : the MEM stage has an outstanding access that is not ready
// The pipeline-register write enables and the ID/EX bubble are combinational,
// so a hazard takes effect in the cycle it is detected. The winning hazard
// is registered as the state, which is also presented as stall_cause.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   id_rs, id_rs2  ID-stage source registers
//   id_use_rs2     ID instruction reads rs2
//   id_br          ID instruction is a branch/jump that reads busA in ID
//   ex_reg_wr      EX instruction writes a register
//   ex_load        EX instruction is a load
//   ex_rd          EX destination register
//   mem_reg_wr     MEM instruction writes a register
//   mem_load       MEM instruction is a load
//   mem_req        MEM stage memory access request
//   mem_rd         MEM destination register
//   mem_ready      memory access completes this cycle
//   pc_en .. mem_wb_en  pipeline-register write enables
//   id_ex_bubble   zero the ID/EX control field on the next capture
//   stall_cause    registered state: 00 RUN, 01 LOAD_USE, 10 BRANCH, 11 MEM_WAIT
//   stall_cnt      saturating count of stall cycles
//   mem_timeout    sticky flag: memory wait reached 255 consecutive cycles
// -----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs2,
   input  logic        id_br,
   input  logic        ex_reg_wr,
   input  logic        ex_load,
   input  logic [4:0]  ex_rd,
   input  logic        mem_reg_wr,
   input  logic        mem_load,
   input  logic        mem_req,
   input  logic [4:0]  mem_rd,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        id_ex_bubble,
   output logic [1:0]  stall_cause,
   output logic [15:0] stall_cnt,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LOAD_USE = 2'b01,
      ST_BRANCH   = 2'b10,
      ST_MEM_WAIT = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_timeout_q, mem_timeout_d;

   logic ex_wr_valid, mem_wr_valid;
   logic ex_match_rs, ex_match_rs2, mem_match_rs;
   logic lu_haz, br_haz, mw_haz, any_haz;

   // Register 0 is hard-wired, so a writer targeting it never creates a hazard.
   assign ex_wr_valid  = ex_reg_wr  & (ex_rd  != 5'd0);
   assign mem_wr_valid = mem_reg_wr & (mem_rd != 5'd0);

   assign ex_match_rs  = ex_wr_valid  & (ex_rd  == id_rs);
   assign ex_match_rs2 = ex_wr_valid  & (ex_rd  == id_rs2);
   assign mem_match_rs = mem_wr_valid & (mem_rd == id_rs);

   assign lu_haz  = ex_load & (ex_match_rs | (id_use_rs2 & ex_match_rs2));
   // A branch resolves in ID, so even an ALU result in EX is too late; a load
   // in MEM is still too late because its data only appears at WB.
   assign br_haz  = id_br & (ex_match_rs | (mem_load & mem_match_rs));
   assign mw_haz  = mem_req & ~mem_ready;
   assign any_haz = mw_haz | br_haz | lu_haz;

   // Enables and bubble follow the current inputs directly. While reset is
   // held every enable is forced on so downstream registers take their own
   // reset values.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      id_ex_bubble = 1'b0;
      if (reset) begin
         if (mw_haz) begin
            // Full freeze: nothing moves, and the ID/EX content is kept.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
         end else if (br_haz || lu_haz) begin
            // Hold the front end and inject a bubble; the back end drains.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      if (mw_haz)      state_d = ST_MEM_WAIT;
      else if (br_haz) state_d = ST_BRANCH;
      else if (lu_haz) state_d = ST_LOAD_USE;
      else             state_d = ST_RUN;

      stall_cnt_d = stall_cnt_q;
      if (any_haz && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;

      // Counts consecutive wait cycles and parks at 255 once reached.
      wait_cnt_d = 8'd0;
      if (mw_haz)
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

      mem_timeout_d = mem_timeout_q | (mw_haz & (wait_cnt_d == 8'hFF));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         stall_cnt_q   <= 16'd0;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_cnt_q   <= stall_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign stall_cause = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed self-checking bench for hazard_ctrl. Inputs change 1 ns after a
// rising edge; combinational outputs are sampled 1 ns later, registered
// outputs 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rs2;
   logic        id_use_rs2, id_br;
   logic        ex_reg_wr, ex_load;
   logic [4:0]  ex_rd;
   logic        mem_reg_wr, mem_load, mem_req;
   logic [4:0]  mem_rd;
   logic        mem_ready;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble;
   logic [1:0]  stall_cause;
   logic [15:0] stall_cnt;
   logic        mem_timeout;
   logic [5:0]  en_vec;

   int tests_run    = 0;
   int tests_failed = 0;

   // {pc, if_id, id_ex, ex_mem, mem_wb, bubble}
   localparam logic [5:0] EN_RUN    = 6'b111110;
   localparam logic [5:0] EN_BUBBLE = 6'b001111;
   localparam logic [5:0] EN_FREEZE = 6'b000000;

   hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rs2       (id_rs2),
      .id_use_rs2   (id_use_rs2),
      .id_br        (id_br),
      .ex_reg_wr    (ex_reg_wr),
      .ex_load      (ex_load),
      .ex_rd        (ex_rd),
      .mem_reg_wr   (mem_reg_wr),
      .mem_load     (mem_load),
      .mem_req      (mem_req),
      .mem_rd       (mem_rd),
      .mem_ready    (mem_ready),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .id_ex_bubble (id_ex_bubble),
      .stall_cause  (stall_cause),
      .stall_cnt    (stall_cnt),
      .mem_timeout  (mem_timeout)
   );

   assign en_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs      = 5'd0;
      id_rs2     = 5'd0;
      id_use_rs2 = 1'b0;
      id_br      = 1'b0;
      ex_reg_wr  = 1'b0;
      ex_load    = 1'b0;
      ex_rd      = 5'd0;
      mem_reg_wr = 1'b0;
      mem_load   = 1'b0;
      mem_req    = 1'b0;
      mem_rd     = 5'd0;
      mem_ready  = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      #1;
      // Reset state
      check("rst_cause",   32'(stall_cause), 32'd0);
      check("rst_cnt",     32'(stall_cnt),   32'd0);
      check("rst_timeout", 32'(mem_timeout), 32'd0);
      check("rst_en",      32'(en_vec),      32'(EN_RUN));
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("idle_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("idle_cause", 32'(stall_cause), 32'd0);

      // Load-use on rs
      ex_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      #1;
      check("lu_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      clear_inputs();
      #1;
      check("lu_cause", 32'(stall_cause), 32'd1);
      check("lu_cnt",   32'(stall_cnt),   32'd1);
      check("lu_after_en", 32'(en_vec), 32'(EN_RUN));

      // Load-use on rs2, only when rs2 is actually read
      ex_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd7; id_rs = 5'd1; id_rs2 = 5'd7;
      id_use_rs2 = 1'b1;
      #1;
      check("lu_rs2_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      id_use_rs2 = 1'b0;
      #1;
      check("lu_rs2_unused_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("lu_rs2_cnt", 32'(stall_cnt), 32'd2);
      check("lu_rs2_cause", 32'(stall_cause), 32'd0);

      // Register 0 never hazards
      clear_inputs();
      ex_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
      #1;
      check("r0_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("r0_cnt", 32'(stall_cnt), 32'd2);

      // Load-to-branch: two stall cycles
      clear_inputs();
      id_br = 1'b1; id_rs = 5'd3;
      ex_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd3;
      #1;
      check("lb_c1_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      check("lb_c1_cause", 32'(stall_cause), 32'd2);
      ex_load = 1'b0; ex_reg_wr = 1'b0; ex_rd = 5'd0;
      mem_load = 1'b1; mem_reg_wr = 1'b1; mem_rd = 5'd3;
      #1;
      check("lb_c2_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      check("lb_c2_cause", 32'(stall_cause), 32'd2);
      mem_load = 1'b0; mem_reg_wr = 1'b0; mem_rd = 5'd0;
      #1;
      check("lb_c3_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("lb_c3_cause", 32'(stall_cause), 32'd0);
      check("lb_cnt", 32'(stall_cnt), 32'd4);

      // ALU producer in EX stalls a branch; ALU result in MEM does not
      ex_reg_wr = 1'b1; ex_rd = 5'd3;
      #1;
      check("br_alu_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      check("br_alu_cause", 32'(stall_cause), 32'd2);
      ex_reg_wr = 1'b0; ex_rd = 5'd0;
      mem_reg_wr = 1'b1; mem_rd = 5'd3;
      #1;
      check("br_mem_alu_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("br_alu_cnt", 32'(stall_cnt), 32'd5);

      // Priority: memory wait over load-use, then load-use applies at once
      clear_inputs();
      mem_req = 1'b1; mem_ready = 1'b0;
      ex_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("pri_freeze_en", 32'(en_vec), 32'(EN_FREEZE));
         tick();
         check("pri_freeze_cause", 32'(stall_cause), 32'd3);
      end
      mem_ready = 1'b1;
      #1;
      check("pri_bubble_en", 32'(en_vec), 32'(EN_BUBBLE));
      tick();
      check("pri_bubble_cause", 32'(stall_cause), 32'd1);
      check("pri_cnt", 32'(stall_cnt), 32'd9);

      // Ready in the same cycle as the request: no stall
      clear_inputs();
      mem_req = 1'b1; mem_ready = 1'b1;
      #1;
      check("rdy_same_en", 32'(en_vec), 32'(EN_RUN));
      tick();
      check("rdy_same_cnt", 32'(stall_cnt), 32'd9);

      // Asynchronous reset in the middle of a memory wait
      mem_ready = 1'b0;
      tick();
      tick();
      check("mw_pre_rst_cause", 32'(stall_cause), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_cause", 32'(stall_cause), 32'd0);
      check("async_rst_cnt",   32'(stall_cnt),   32'd0);
      check("async_rst_en",    32'(en_vec),      32'(EN_RUN));
      tick();
      reset = 1'b1;
      #1;
      check("post_rst_cause", 32'(stall_cause), 32'd0);
      check("post_rst_en", 32'(en_vec), 32'(EN_FREEZE));

      // Timeout: 300 wait cycles from a clean count
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 254) check("tmo_254", 32'(mem_timeout), 32'd0);
         if (i == 255) check("tmo_255", 32'(mem_timeout), 32'd1);
      end
      check("tmo_cnt",   32'(stall_cnt),   32'd300);
      check("tmo_cause", 32'(stall_cause), 32'd3);
      mem_ready = 1'b1;
      tick();
      check("tmo_sticky",      32'(mem_timeout), 32'd1);
      check("tmo_after_cause", 32'(stall_cause), 32'd0);
      check("tmo_after_cnt",   32'(stall_cnt),   32'd300);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
